// File: rtl/rv32_mem_pkg.sv
// Shared types and constants for the RV32 single-port memory arbiter.
package rv32_mem_pkg;
  localparam int XLEN = 32;
  localparam int BE_W = 4;
  localparam logic [XLEN-1:0] RV32_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } mem_cmd_t;
endpackage

// File: rtl/memarb_wdog.sv
// Busy-cycle watchdog: expires on the LIMIT-th consecutive enabled cycle.
module memarb_wdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign expire = en && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr)          cnt <= '0;
    else if (en && !expire)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter_rv32.sv
// Shares one memory port between fetch and LSU, one transaction at a time.
// Optional watchdog abort enabled with MEMARB_TIMEOUT_EN.
module mem_port_arbiter_rv32
  import rv32_mem_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iIReq,
  input  logic [XLEN-1:0] iIAddr,
  input  logic            iFlush,
  output logic            oIValid,
  output logic [XLEN-1:0] oIData,
  output logic            oStallI,
  input  logic            iDReq,
  input  logic            iDWe,
  input  logic [XLEN-1:0] iDAddr,
  input  logic [XLEN-1:0] iDWData,
  input  logic [BE_W-1:0] iDBe,
  output logic            oDValid,
  output logic [XLEN-1:0] oDData,
  output logic            oStallD,
  output logic            oMReq,
  output logic            oMWe,
  output logic [XLEN-1:0] oMAddr,
  output logic [XLEN-1:0] oMWData,
  output logic [BE_W-1:0] oMBe,
  input  logic            iMAck,
  input  logic [XLEN-1:0] iMRData,
  output logic            oErr
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);

  arb_state_e   state, state_nx;
  mem_cmd_t     cmd;
  logic         m_req;
  logic [SW-1:0] streak;
  logic         streak_max;
  logic         drop;
  logic         grant_i, grant_d, done, tmo;

  logic unused_addr;
  assign unused_addr = &{1'b0, iIAddr[1:0]};

`ifdef MEMARB_TIMEOUT_EN
  memarb_wdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clk    (iCLK),
    .rst    (iRST),
    .clr    (state == IDLE),
    .en     ((state != IDLE) && !iMAck),
    .expire (tmo)
  );
`else
  logic unused_cfg;
  assign unused_cfg = &{1'b0, TIMEOUT_CYC[0]};
  assign tmo = 1'b0;
`endif

  assign streak_max = (streak == SW'(MAX_D_STREAK));

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    done     = 1'b0;
    oIValid  = 1'b0;
    oDValid  = 1'b0;
    oIData   = iMRData;
    oDData   = iMRData;
    oErr     = 1'b0;
    case (state)
      IDLE: begin
        // LSU wins unless it has starved a waiting fetch for MAX_D_STREAK grants
        if (iDReq && !(iIReq && streak_max)) begin
          grant_d  = 1'b1;
          state_nx = D_BUSY;
        end else if (iIReq) begin
          grant_i  = 1'b1;
          state_nx = I_BUSY;
        end
      end
      I_BUSY: begin
        if (iMAck || tmo) begin
          done     = 1'b1;
          state_nx = IDLE;
          oIValid  = !(drop || iFlush);
          if (tmo) begin
            oIData = RV32_NOP;
            oErr   = 1'b1;
          end
        end
      end
      D_BUSY: begin
        if (iMAck || tmo) begin
          done     = 1'b1;
          state_nx = IDLE;
          oDValid  = 1'b1;
          if (tmo) begin
            oDData = '0;
            oErr   = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign oStallI = iIReq && !oIValid;
  assign oStallD = iDReq && !oDValid;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      m_req <= 1'b0;
      cmd   <= '0;
    end else if (grant_d) begin
      m_req <= 1'b1;
      cmd   <= '{we: iDWe, addr: iDAddr, wdata: iDWData, be: iDBe};
    end else if (grant_i) begin
      m_req <= 1'b1;
      cmd   <= '{we: 1'b0, addr: {iIAddr[XLEN-1:2], 2'b00}, wdata: '0, be: '1};
    end else if (done) begin
      m_req <= 1'b0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST)         streak <= '0;
    else if (grant_i) streak <= '0;
    else if (grant_d) begin
      if (!iIReq)          streak <= '0;
      else if (!streak_max) streak <= streak + 1'b1;
    end
  end

  // Flush in the ack cycle is handled combinationally; the flag only covers later cycles
  always_ff @(posedge iCLK) begin
    if (iRST)                            drop <= 1'b0;
    else if (state == I_BUSY && done)    drop <= 1'b0;
    else if (state == I_BUSY && iFlush)  drop <= 1'b1;
  end

  assign oMReq   = m_req;
  assign oMWe    = cmd.we;
  assign oMAddr  = cmd.addr;
  assign oMWData = cmd.wdata;
  assign oMBe    = cmd.be;
endmodule

// File: tb/tb_mem_port_arbiter_rv32.sv
// Scoreboard bench for mem_port_arbiter_rv32; memory model returns ~addr as read data.
module tb_mem_port_arbiter_rv32;
`ifdef MEMARB_TIMEOUT_EN
  localparam int TCYC = 8;
`else
  localparam int TCYC = 255;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          full;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, flush, d_req, d_we, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_be;
  logic        i_valid, stall_i, d_valid, stall_d, m_req, m_we, err;
  logic [31:0] i_data, d_data, m_addr, m_wdata;
  logic [3:0]  m_be;

  cmd_t        exp_cmd[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  int          n_chk = 0, n_pass = 0;
  bit          mem_en = 1'b1;
  int          ack_lat = 0;
  bit          err_ok = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter_rv32 #(.MAX_D_STREAK(4), .TIMEOUT_CYC(TCYC)) dut (
    .iCLK(clk), .iRST(rst),
    .iIReq(i_req), .iIAddr(i_addr), .iFlush(flush),
    .oIValid(i_valid), .oIData(i_data), .oStallI(stall_i),
    .iDReq(d_req), .iDWe(d_we), .iDAddr(d_addr), .iDWData(d_wdata), .iDBe(d_be),
    .oDValid(d_valid), .oDData(d_data), .oStallD(stall_d),
    .oMReq(m_req), .oMWe(m_we), .oMAddr(m_addr), .oMWData(m_wdata), .oMBe(m_be),
    .iMAck(m_ack), .iMRData(m_rdata), .oErr(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_for(input int which, input int max, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = (i_valid === 1'b1);
        1:       seen = (d_valid === 1'b1);
        default: seen = (err === 1'b1);
      endcase
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  function automatic cmd_t mk(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, input bit full);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = wd; c.be = be; c.full = full;
    return c;
  endfunction

  // Memory model: ack on the (ack_lat+1)-th cycle of oMReq
  initial begin
    int cnt = 0;
    m_ack = 1'b0;
    m_rdata = '0;
    forever begin
      step();
      if (mem_en) begin
        if (m_req === 1'b1) begin
          if (cnt == ack_lat) begin
            m_ack = 1'b1; m_rdata = ~m_addr; cnt = 0;
          end else begin
            m_ack = 1'b0; cnt++;
          end
        end else begin
          m_ack = 1'b0; cnt = 0;
        end
      end else cnt = 0;
    end
  end

  // Monitor: compares every new command and every valid pulse against the queues
  initial begin
    logic prev_req = 1'b0;
    cmd_t c;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_req === 1'b1 && !prev_req) begin
          if (exp_cmd.size() == 0) chk("unexpected_cmd", m_addr, 32'hFFFF_FFFF);
          else begin
            c = exp_cmd.pop_front();
            chk("cmd_addr", m_addr, c.addr);
            chk("cmd_we", {31'd0, m_we}, {31'd0, c.we});
            if (c.full) begin
              chk("cmd_wdata", m_wdata, c.wdata);
              chk("cmd_be", {28'd0, m_be}, {28'd0, c.be});
            end
          end
        end
        if (i_valid === 1'b1) begin
          if (exp_i.size() == 0) chk("unexpected_ivalid", i_data, 32'hFFFF_FFFF);
          else chk("i_data", i_data, exp_i.pop_front());
        end
        if (d_valid === 1'b1) begin
          if (exp_d.size() == 0) chk("unexpected_dvalid", d_data, 32'hFFFF_FFFF);
          else chk("d_data", d_data, exp_d.pop_front());
        end
        if (err === 1'b1 && !err_ok) chk("unexpected_err", {31'd0, err}, 32'd0);
      end
      prev_req = (m_req === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; i_req = 0; i_addr = 0; flush = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 4'hF;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mreq", {31'd0, m_req}, 32'd0);
    chk("rst_maddr", m_addr, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_stall_i", {31'd0, stall_i}, 32'd0);

    // T1 fetch only, ack in first oMReq cycle
    step();
    i_req = 1; i_addr = 32'h100;
    exp_cmd.push_back(mk(0, 32'h100, 0, 0, 0));
    exp_i.push_back(32'hFFFF_FEFF);
    @(negedge clk);
    chk("t1_stall_c1", {31'd0, stall_i}, 32'd1);
    step();
    @(negedge clk);
    chk("t1_ivalid_c2", {31'd0, i_valid}, 32'd1);
    chk("t1_stall_c2", {31'd0, stall_i}, 32'd0);
    step(); i_req = 0;
    step();

    // low address bits forced to zero on the port
    i_req = 1; i_addr = 32'h303;
    exp_cmd.push_back(mk(0, 32'h300, 0, 0, 0));
    exp_i.push_back(32'hFFFF_FCFF);
    wait_for(0, 20, "t1b_ivalid");
    step(); i_req = 0;
    step();

    // T2 contention: D,D,D,D,I then D
    i_req = 1; i_addr = 32'h500;
    d_req = 1; d_we = 0; d_addr = 32'h2000; d_wdata = 0; d_be = 4'hF;
    for (int k = 0; k < 4; k++) begin
      exp_cmd.push_back(mk(0, 32'h2000, 0, 4'hF, 1));
      exp_d.push_back(32'hFFFF_DFFF);
    end
    exp_cmd.push_back(mk(0, 32'h500, 0, 0, 0));
    exp_i.push_back(32'hFFFF_FAFF);
    exp_cmd.push_back(mk(0, 32'h2000, 0, 4'hF, 1));
    exp_d.push_back(32'hFFFF_DFFF);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (i_valid === 1'b1) break;
      if (stall_i === 1'b1) n++;
    end
    chk("t2_stall_cycles", n, 32'd9);
    step(); i_req = 0;
    wait_for(1, 20, "t2_last_dvalid");
    step(); d_req = 0;
    step();

    // T3 flush in first busy cycle, slow memory
    ack_lat = 3;
    i_req = 1; i_addr = 32'h200;
    exp_cmd.push_back(mk(0, 32'h200, 0, 0, 0));
    exp_cmd.push_back(mk(0, 32'h400, 0, 0, 0));
    exp_i.push_back(32'hFFFF_FBFF);
    step();
    flush = 1; i_addr = 32'h400;
    step();
    flush = 0;
    wait_for(0, 30, "t3_ivalid_new");
    step(); i_req = 0;
    step();

    // T3b flush exactly in the ack cycle
    ack_lat = 1;
    i_req = 1; i_addr = 32'h600;
    exp_cmd.push_back(mk(0, 32'h600, 0, 0, 0));
    exp_cmd.push_back(mk(0, 32'h604, 0, 0, 0));
    exp_i.push_back(32'hFFFF_F9FB);
    step(); step();
    flush = 1; i_addr = 32'h604;
    step();
    flush = 0;
    wait_for(0, 20, "t3b_ivalid_new");
    step(); i_req = 0;
    step();

    // T4 store, flush held high has no effect on LSU
    d_req = 1; d_we = 1; d_addr = 32'h1004; d_wdata = 32'hA5A5; d_be = 4'b0011;
    flush = 1;
    exp_cmd.push_back(mk(1, 32'h1004, 32'hA5A5, 4'b0011, 1));
    exp_d.push_back(32'hFFFF_EFFB);
    @(negedge clk);
    chk("t4_stall_d", {31'd0, stall_d}, 32'd1);
    wait_for(1, 20, "t4_dvalid");
    step(); d_req = 0; d_we = 0; flush = 0; d_be = 4'hF; d_wdata = 0;
    step();

    // T5 reset mid D_BUSY, late ack ignored
    mem_en = 0; m_ack = 0;
    d_req = 1; d_addr = 32'h3000;
    exp_cmd.push_back(mk(0, 32'h3000, 0, 4'hF, 1));
    step();
    @(negedge clk);
    chk("t5_mreq_busy", {31'd0, m_req}, 32'd1);
    step();
    rst = 1;
    step();
    rst = 0; d_req = 0;
    m_ack = 1; m_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("t5_mreq_after_rst", {31'd0, m_req}, 32'd0);
    chk("t5_maddr_after_rst", m_addr, 32'd0);
    chk("t5_dvalid_late_ack", {31'd0, d_valid}, 32'd0);
    step(); m_ack = 0;
    @(negedge clk);
    chk("t5_mreq_stays_low", {31'd0, m_req}, 32'd0);
    mem_en = 1; ack_lat = 0;
    step();

`ifdef MEMARB_TIMEOUT_EN
    // T6 fetch never acked; watchdog aborts after TCYC busy cycles
    mem_en = 0; m_ack = 0; err_ok = 1;
    i_req = 1; i_addr = 32'h700;
    exp_cmd.push_back(mk(0, 32'h700, 0, 0, 0));
    exp_i.push_back(32'h0000_0013);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (m_req === 1'b1) n++;
      if (err === 1'b1) break;
    end
    chk("t6_busy_cycles", n, TCYC);
    chk("t6_err", {31'd0, err}, 32'd1);
    chk("t6_ivalid", {31'd0, i_valid}, 32'd1);
    step(); i_req = 0;
    @(negedge clk);
    chk("t6_mreq_low", {31'd0, m_req}, 32'd0);
    chk("t6_err_pulse", {31'd0, err}, 32'd0);
    err_ok = 0; mem_en = 1;
    step();
`endif

    step();
    chk("cmd_q_empty", exp_cmd.size(), 32'd0);
    chk("i_q_empty", exp_i.size(), 32'd0);
    chk("d_q_empty", exp_d.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
